// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared state encoding and mode constants for the run controller
package run_ctrl_pkg;
  typedef enum logic [1:0] {HALT = 2'd0, RUN = 2'd1, BURST = 2'd2} run_state_t;
  localparam logic [1:0] MODE_FULL  = 2'd0;
  localparam logic [1:0] MODE_SLOW  = 2'd1;
  localparam logic [1:0] MODE_STEP  = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;
endpackage

// File: rtl/btn_sync_pulse.sv
// btn_sync_pulse: synchronise, debounce and turn an active-low button press into a one-clock pulse
module btn_sync_pulse #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_n,
  output logic press
);
  localparam int CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_prev;
  logic          r_arm;
  logic          r_press;
  logic          w_diff;
  assign w_diff = r_sync[1] != r_level;
  assign press  = r_press;
  // synchroniser starts low so a key held through reset never arms; press needs a released sample first
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_prev  <= 1'b1;
      r_arm   <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], btn_n};
      r_arm   <= r_arm | r_sync[1];
      r_prev  <= r_level;
      r_press <= r_arm & r_prev & ~r_level;
      if (!w_diff) r_cnt <= '0;
      else if (r_cnt == LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
      end else r_cnt <= r_cnt + CW'(1);
    end
endmodule

// File: rtl/pipe_run_ctrl.sv
// pipe_run_ctrl: single-clock cpu enable generator with run, slow, step, burst, breakpoint and halt
module pipe_run_ctrl import run_ctrl_pkg::*; #(
  parameter int RUN_DIV    = 50_000_000,
  parameter int DEB_CYCLES = 500_000,
  parameter int PC_WIDTH   = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic                 step_btn_n,
  input  logic [CNT_WIDTH-1:0] burst_len,
  input  logic                 bp_en,
  input  logic [PC_WIDTH-1:0]  bp_addr,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 halt_req,
  output logic                 cpu_en,
  output logic                 running,
  output logic                 bp_hit,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [1:0]           state
);
  localparam int DW = $clog2(RUN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);
  run_state_t           r_state;
  logic                 r_cpu_en;
  logic                 r_running;
  logic                 r_bp_hit;
  logic                 r_resume;
  logic [CNT_WIDTH-1:0] r_cycle_count;
  logic [CNT_WIDTH-1:0] r_burst_cnt;
  logic [DW-1:0]        r_div;
  logic [1:0]           r_mode_q;
  logic                 w_press;
  logic                 w_tick;
  logic                 w_bp;
  logic                 w_mode_chg;
  btn_sync_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
    .clock (clock),
    .reset (reset),
    .btn_n (step_btn_n),
    .press (w_press)
  );
  assign w_tick      = (mode != MODE_SLOW) || (r_div == DIV_LAST);
  assign w_bp        = bp_en && (pc == bp_addr) && !r_resume;
  assign w_mode_chg  = mode != r_mode_q;
  assign cpu_en      = r_cpu_en;
  assign running     = r_running;
  assign bp_hit      = r_bp_hit;
  assign cycle_count = r_cycle_count;
  assign state       = r_state;
  // run-control FSM: priority halt_req > breakpoint > press/mode change > tick
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state       <= HALT;
      r_cpu_en      <= 1'b0;
      r_running     <= 1'b0;
      r_bp_hit      <= 1'b0;
      r_resume      <= 1'b0;
      r_cycle_count <= '0;
      r_burst_cnt   <= '0;
      r_div         <= '0;
      r_mode_q      <= MODE_FULL;
    end else begin
      r_cpu_en <= 1'b0;
      r_mode_q <= mode;
      case (r_state)
        HALT: begin
          r_div <= '0;
          if (w_press && !halt_req) begin
            r_bp_hit <= 1'b0;
            r_resume <= 1'b1;
            if (mode == MODE_STEP) begin
              r_cpu_en      <= 1'b1;
              r_resume      <= 1'b0;
              r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
            end else if (mode != MODE_BURST) begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end else if (burst_len != '0) begin
              r_burst_cnt <= burst_len;
              r_state     <= BURST;
              r_running   <= 1'b1;
            end
          end
        end
        RUN, BURST: begin
          r_div <= w_tick ? '0 : r_div + DW'(1);
          if (halt_req || (w_tick && w_bp) || w_press || w_mode_chg) begin
            r_state   <= HALT;
            r_running <= 1'b0;
            r_bp_hit  <= r_bp_hit | (!halt_req && w_tick && w_bp);
          end else if (w_tick) begin
            r_cpu_en      <= 1'b1;
            r_resume      <= 1'b0;
            r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
            if (r_state == BURST) begin
              r_burst_cnt <= r_burst_cnt - CNT_WIDTH'(1);
              if (r_burst_cnt == CNT_WIDTH'(1)) begin
                r_state   <= HALT;
                r_running <= 1'b0;
              end
            end
          end
        end
        default: begin
          r_state   <= HALT;
          r_running <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_pipe_run_ctrl.sv
// tb_pipe_run_ctrl: scoreboard bench for the run controller with short debounce and divider
module tb_pipe_run_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        step_btn_n = 1'b1;
  logic [15:0] burst_len = 16'd0;
  logic        bp_en = 1'b0;
  logic [15:0] bp_addr = 16'd0;
  logic [15:0] pc = 16'd0;
  logic        pc_clr = 1'b1;
  logic        halt_req = 1'b0;
  logic        cpu_en;
  logic        running;
  logic        bp_hit;
  logic [15:0] cycle_count;
  logic [1:0]  state;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          q[$];
  int          p;

  pipe_run_ctrl #(.RUN_DIV(3), .DEB_CYCLES(4), .PC_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clock       (clk),
    .reset       (rst),
    .mode        (mode),
    .step_btn_n  (step_btn_n),
    .burst_len   (burst_len),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .pc          (pc),
    .halt_req    (halt_req),
    .cpu_en      (cpu_en),
    .running     (running),
    .bp_hit      (bp_hit),
    .cycle_count (cycle_count),
    .state       (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) pc <= pc_clr ? 16'd0 : (cpu_en ? pc + 16'd4 : pc);

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk)
    if (cpu_en) begin
      if (q.size() == 0) chk("spurious_en", cpu_en, 0);
      else chk("en_cycle", cyc, q.pop_front());
    end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset();
    chk("queue_drained", q.size(), 0);
    rst = 1'b1;
    pc_clr = 1'b1;
    step_btn_n = 1'b1;
    halt_req = 1'b0;
    bp_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_running", running, 0);
    chk("rst_bp_hit", bp_hit, 0);
    chk("rst_count", cycle_count, 0);
    chk("rst_state", state, 0);
    rst = 1'b0;
    pc_clr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic press(input int hold, input int off, input int n, input int stride, output int pp);
    repeat (12) @(negedge clk);
    pp = cyc + 8;
    for (int i = 0; i < n; i++) q.push_back(pp + off + i * stride);
    step_btn_n = 1'b0;
    repeat (hold) @(negedge clk);
    step_btn_n = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    do_reset();
    mode = 2'd2;
    step_btn_n = 1'b0;
    repeat (2) @(negedge clk);
    step_btn_n = 1'b1;
    press(10, 0, 1, 1, p);
    wait_cyc(p + 4);
    chk("step_count", cycle_count, 1);
    chk("step_state", state, 0);
    chk("step_running", running, 0);

    do_reset();
    mode = 2'd3;
    burst_len = 16'd5;
    press(10, 1, 5, 1, p);
    wait_cyc(p + 3);
    chk("burst_mid_state", state, 2);
    chk("burst_mid_running", running, 1);
    wait_cyc(p + 7);
    chk("burst_end_state", state, 0);
    chk("burst_end_running", running, 0);
    chk("burst_count", cycle_count, 5);
    burst_len = 16'd0;
    press(10, 0, 0, 1, p);
    wait_cyc(p + 4);
    chk("burst0_state", state, 0);
    chk("burst0_count", cycle_count, 5);

    do_reset();
    mode = 2'd1;
    press(6, 3, 5, 3, p);
    wait_cyc(p + 1);
    chk("slow_state", state, 1);
    chk("slow_running", running, 1);
    wait_cyc(p + 16);
    mode = 2'd0;
    wait_cyc(p + 17);
    chk("modechg_state", state, 0);
    chk("modechg_running", running, 0);
    chk("slow_count", cycle_count, 5);

    do_reset();
    mode = 2'd0;
    bp_en = 1'b1;
    bp_addr = 16'h0010;
    press(6, 1, 4, 1, p);
    wait_cyc(p + 6);
    chk("bp_state", state, 0);
    chk("bp_hit_set", bp_hit, 1);
    chk("bp_count", cycle_count, 4);
    press(6, 1, 5, 1, p);
    wait_cyc(p);
    chk("bp_hit_clear", bp_hit, 0);
    chk("resume_running", running, 1);
    wait_cyc(p + 5);
    halt_req = 1'b1;
    wait_cyc(p + 6);
    halt_req = 1'b0;
    chk("halt_state", state, 0);
    chk("halt_running", running, 0);
    chk("halt_count", cycle_count, 9);
    wait_cyc(p + 12);
    chk("halt_frozen", cycle_count, 9);

    do_reset();
    mode = 2'd3;
    burst_len = 16'd8;
    press(6, 1, 3, 1, p);
    wait_cyc(p + 3);
    #1 rst = 1'b1;
    #1;
    chk("arst_cpu_en", cpu_en, 0);
    chk("arst_state", state, 0);
    chk("arst_running", running, 0);
    chk("arst_count", cycle_count, 0);
    step_btn_n = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    step_btn_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("held_no_press_count", cycle_count, 0);
    chk("held_no_press_state", state, 0);
    press(6, 1, 8, 1, p);
    wait_cyc(p + 10);
    chk("burst8_count", cycle_count, 8);
    chk("burst8_state", state, 0);
    chk("final_queue", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
